ram_port_arbiter: RTL and testbench

- Shares the single-port data RAM between the ARM core's data port (load/store) and the VGA pixel reader in the histogram equalizer top.
- Grants one access per cycle and returns read data to the owner one cycle later.
- Favours VGA to meet display deadlines, but guarantees the CPU a slot after a bounded run of VGA grants.
- Drives the core's stall so a blocked load/store holds the processor.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/arb_streak_counter.sv | 41 ++++
 rtl/ram_port_arbiter.sv | 88 ++++++++
 tb/tb_ram_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
// Owner encoding records which requester receives ram_rd on the next cycle.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2
  } owner_t;

  // Width of a counter that must represent 0..max inclusive.
  function automatic int streak_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive VGA grants suffered by a waiting CPU request.
// Clear has priority over increment; the count never wraps past MAX.
module arb_streak_counter
  import ram_arb_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = streak_w(MAX)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MaxVal);

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port data RAM shared between the CPU load/store port and the VGA reader.
// VGA is favoured, but a waiting CPU wins after VGA_STREAK_MAX consecutive VGA grants.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int VGA_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              cpu_stall,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rd,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wd,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rd
);

  logic              at_max;
  logic              cpu_win, vga_win;
  owner_t            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;

  // Grants are forced low while reset is asserted, independent of the clock.
  always_comb begin
    cpu_win = 1'b0;
    vga_win = 1'b0;
    if (rst) begin
      cpu_win = cpu_req & (~vga_req | at_max);
      vga_win = vga_req & ~cpu_win;
    end
  end

  assign cpu_gnt   = cpu_win;
  assign vga_gnt   = vga_win;
  assign cpu_stall = cpu_req & ~cpu_win;
  assign ram_we    = cpu_win & cpu_we;
  assign ram_addr  = cpu_win ? cpu_addr : (vga_win ? vga_addr : addr_q);
  assign ram_wd    = cpu_win ? cpu_wd : wd_q;

  arb_streak_counter #(
    .MAX (VGA_STREAK_MAX)
  ) u_streak (
    .clk      (clk),
    .rst_n    (rst),
    .inc_i    (vga_win & cpu_req),
    .clr_i    (cpu_win | ~cpu_req),
    .at_max_o (at_max)
  );

  // Owner FSM plus the held RAM address/data used when nobody is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      addr_q <= ram_addr;
      wd_q   <= ram_wd;
      if (cpu_win) begin
        owner_q <= cpu_we ? OWN_NONE : OWN_CPU;
      end else if (vga_win) begin
        owner_q <= OWN_VGA;
      end else begin
        owner_q <= OWN_NONE;
      end
    end
  end

  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign vga_rvalid = (owner_q == OWN_VGA);
  assign cpu_rd     = ram_rd;
  assign vga_rd     = ram_rd;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a reference model predicts grants and read
// responses into queues; a separate monitor pops and compares when rvalid appears.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wd = '0;
  logic          cpu_gnt, cpu_rvalid, cpu_stall;
  logic [DW-1:0] cpu_rd;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          vga_gnt, vga_rvalid;
  logic [DW-1:0] vga_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wd;
  logic          ram_we;
  logic [DW-1:0] ram_rd;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .VGA_STREAK_MAX (SMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wd     (cpu_wd),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rd     (cpu_rd),
    .cpu_stall  (cpu_stall),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_gnt    (vga_gnt),
    .vga_rvalid (vga_rvalid),
    .vga_rd     (vga_rd),
    .ram_addr   (ram_addr),
    .ram_wd     (ram_wd),
    .ram_we     (ram_we),
    .ram_rd     (ram_rd)
  );

  // Power-on RAM contents; address 0x0010 holds a known pattern.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 16'h0010) return 32'hDEAD_BEEF;
    return {a, ~a} ^ 32'h5A5A_3C3C;
  endfunction

  // Physical single-port RAM: address and write registered at the edge, 1-cycle read.
  logic [DW-1:0] ram     [0:65535];
  bit            written [0:65535];
  always @(posedge clk) begin
    ram_rd <= written[ram_addr] ? ram[ram_addr] : init_val(ram_addr);
    if (ram_we) begin
      ram[ram_addr]     <= ram_wd;
      written[ram_addr] <= 1'b1;
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state: logical memory view, scoreboard queues, grant history.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] ref_mem [int];
  rsp_t          cpu_q[$];
  rsp_t          vga_q[$];
  int            m_streak = 0;
  logic [AW-1:0] m_last_addr = '0;
  bit            m_cpu_gnt = 1'b0, m_vga_gnt = 1'b0;
  bit            log_en = 1'b0;
  string         glog = "";
  logic [DW-1:0] last_cpu_rd = '0, last_vga_rd = '0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  task automatic model_step();
    bit cw, vw;
    if (!rst) begin
      check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check("rst_vga_gnt", 32'(vga_gnt), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_ram_wd", ram_wd, 32'd0);
      check("rst_cpu_stall", 32'(cpu_stall), 32'(cpu_req));
      m_streak    = 0;
      m_last_addr = '0;
      m_cpu_gnt   = 1'b0;
      m_vga_gnt   = 1'b0;
      return;
    end
    // The CPU gets the port if VGA is idle or it has already waited out SMAX VGA grants.
    cw = cpu_req && (!vga_req || m_streak >= SMAX);
    vw = vga_req && !cw;
    check("cpu_gnt", 32'(cpu_gnt), 32'(cw));
    check("vga_gnt", 32'(vga_gnt), 32'(vw));
    check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !cw));
    check("ram_we", 32'(ram_we), 32'(cw && cpu_we));
    if (cw) begin
      check("ram_addr_cpu", 32'(ram_addr), 32'(cpu_addr));
      m_last_addr = cpu_addr;
      if (cpu_we) begin
        check("ram_wd", ram_wd, cpu_wd);
        ref_mem[int'(cpu_addr)] = cpu_wd;
      end else begin
        cpu_q.push_back('{due: cyc + 1, data: ref_rd(cpu_addr)});
      end
    end else if (vw) begin
      check("ram_addr_vga", 32'(ram_addr), 32'(vga_addr));
      m_last_addr = vga_addr;
      vga_q.push_back('{due: cyc + 1, data: ref_rd(vga_addr)});
    end else begin
      check("ram_addr_hold", 32'(ram_addr), 32'(m_last_addr));
    end
    if (cw || !cpu_req) m_streak = 0;
    else if (vw && m_streak < SMAX) m_streak++;
    if (log_en) glog = {glog, cw ? "C" : (vw ? "V" : "-")};
    m_cpu_gnt = cw;
    m_vga_gnt = vw;
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  // Monitor: each cycle an rvalid is expected exactly when a queued response is due.
  initial forever begin
    bit   ev;
    rsp_t r;
    @(negedge clk);
    ev = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(ev));
    if (ev) begin
      r = cpu_q.pop_front();
      if (cpu_rvalid) begin
        check("cpu_rd", cpu_rd, r.data);
        last_cpu_rd = cpu_rd;
      end
    end
    ev = (vga_q.size() > 0) && (vga_q[0].due == cyc);
    check("vga_rvalid", 32'(vga_rvalid), 32'(ev));
    if (ev) begin
      r = vga_q.pop_front();
      if (vga_rvalid) begin
        check("vga_rd", vga_rd, r.data);
        last_vga_rd = vga_rd;
      end
    end
  end

  // One requester cycle: granted requests drop, new ones are raised only when idle.
  task automatic step(input bit c_new, input bit c_we, input logic [AW-1:0] c_addr,
                      input logic [DW-1:0] c_wd, input bit v_new, input logic [AW-1:0] v_addr,
                      input bit c_drop);
    @(posedge clk);
    #1;
    if (m_cpu_gnt) cpu_req = 1'b0;
    if (m_vga_gnt) vga_req = 1'b0;
    if (c_drop) begin
      cpu_req = 1'b0;
    end else if (!cpu_req && c_new) begin
      cpu_req  = 1'b1;
      cpu_we   = c_we;
      cpu_addr = c_addr;
      cpu_wd   = c_wd;
    end
    if (!vga_req && v_new) begin
      vga_req  = 1'b1;
      vga_addr = v_addr;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic both(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0040, '0, 1'b1, 16'h0041, 1'b0);
  endtask

  task automatic start_log();
    @(negedge clk);
    #1;
    glog   = "";
    log_en = 1'b1;
  endtask

  task automatic stop_log();
    @(negedge clk);
    #1;
    log_en = 1'b0;
  endtask

  initial begin
    // Reset held with both requesters active: nothing may be granted.
    cpu_req  = 1'b1;
    cpu_addr = 16'h0005;
    vga_req  = 1'b1;
    vga_addr = 16'h0006;
    repeat (3) @(posedge clk);
    start_log();
    @(posedge clk);
    #1;
    rst = 1'b1;
    stop_log();
    check("post_reset_first_grant_vga", 32'(glog == "V"), 32'd1);
    idle(3);

    // CPU-only read of the preloaded word.
    step(1'b1, 1'b0, 16'h0010, '0, 1'b0, '0, 1'b0);
    idle(2);
    check("cpu_read_deadbeef", last_cpu_rd, 32'hDEAD_BEEF);

    // Continuous contention: four VGA grants then one CPU grant, twice.
    start_log();
    both(10);
    stop_log();
    check("contention_pattern", 32'(glog == "VVVVCVVVVC"), 32'd1);
    idle(3);

    // CPU write immediately followed by a VGA read of the same word.
    step(1'b1, 1'b1, 16'h0020, 32'h1234_5678, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 16'h0020, 1'b0);
    idle(2);
    check("write_then_vga_read", last_vga_rd, 32'h1234_5678);

    // A one-cycle gap in cpu_req restarts the streak.
    start_log();
    both(3);
    step(1'b0, 1'b0, '0, '0, 1'b1, 16'h0042, 1'b1);
    both(5);
    stop_log();
    check("streak_clear_pattern", 32'(glog == "VVVVVVVVC"), 32'd1);
    idle(3);

    // Asynchronous reset between a VGA grant and its data edge drops the response.
    step(1'b0, 1'b0, '0, '0, 1'b1, 16'h0030, 1'b0);
    @(negedge clk);
    #2;
    rst     = 1'b0;
    cpu_req = 1'b0;
    vga_req = 1'b0;
    cpu_q.delete();
    vga_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3);

    // Randomised traffic on a small address window to force read-after-write hits.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(99) < 55, 1'($urandom_range(1)), 16'($urandom_range(31)), $urandom(),
           $urandom_range(99) < 70, 16'($urandom_range(31)), 1'b0);
    end
    idle(6);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("vga_q_drained", 32'(vga_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
